// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state type for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_ASR = 3'b110;
  localparam logic [2:0] OP_ROR = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: shift-add multiplier and one-bit-per-step shifter/rotator
// driven by a down-counter loaded with the iteration count.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [2:0]               op,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic [$clog2(WIDTH):0]   n,
  output logic                     last_c,
  output logic [WIDTH-1:0]         value_c
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [2:0]       op_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic             left_q;
  logic [CW-1:0]    cnt_q;

  // Value the accumulator takes after the current step.
  always_comb begin
    value_c = acc_q;
    case (op_q)
      OP_MUL:  value_c = acc_q + (mplier_q[0] ? mcand_q : '0);
      OP_SHL:  value_c = left_q ? {acc_q[WIDTH-2:0], 1'b0} : {1'b0, acc_q[WIDTH-1:1]};
      OP_ASR:  value_c = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      OP_ROR:  value_c = {acc_q[0], acc_q[WIDTH-1:1]};
      default: value_c = acc_q;
    endcase
  end

  assign last_c = (cnt_q == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= OP_FWD;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      left_q   <= 1'b0;
      cnt_q    <= '0;
    end else if (load) begin
      op_q     <= op;
      acc_q    <= (op == OP_MUL) ? '0 : a;
      mcand_q  <= a;
      mplier_q <= b;
      left_q   <= ~b[WIDTH-1];
      cnt_q    <= n;
    end else if (cnt_q != '0) begin
      acc_q    <= value_c;
      mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
      cnt_q    <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: START/BUSY/DONE handshake, single-cycle logic/add ops and
// iterative multiply/shift/rotate, with registered RESULT and ZERO.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned LW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_d;
  logic             zero_d, busy_d, done_d;
  logic             load_c;
  logic             last_c;
  logic [WIDTH-1:0] iter_value_c;

  logic [WIDTH:0]   b_ext_c, mag_c;
  logic [CW-1:0]    shl_n_c, asr_n_c, ror_n_c, n_c;

  // Iteration counts; SHL treats DATA2 as signed, so |-2^(W-1)| needs W+1 bits.
  always_comb begin
    b_ext_c = {DATA2[WIDTH-1], DATA2};
    mag_c   = b_ext_c[WIDTH] ? -b_ext_c : b_ext_c;
    shl_n_c = (mag_c >= (WIDTH+1)'(WIDTH)) ? CW'(WIDTH) : CW'(mag_c);
    asr_n_c = (DATA2 >= WIDTH'(WIDTH)) ? CW'(WIDTH) : CW'(DATA2);
    ror_n_c = CW'(DATA2[LW-1:0]);
    case (SELECT)
      OP_SHL:  n_c = shl_n_c;
      OP_ASR:  n_c = asr_n_c;
      OP_ROR:  n_c = ror_n_c;
      default: n_c = CW'(WIDTH);
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    result_d = RESULT;
    done_d   = 1'b0;
    load_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          case (SELECT)
            OP_FWD: begin result_d = DATA2;         done_d = 1'b1; end
            OP_ADD: begin result_d = DATA1 + DATA2; done_d = 1'b1; end
            OP_AND: begin result_d = DATA1 & DATA2; done_d = 1'b1; end
            OP_OR:  begin result_d = DATA1 | DATA2; done_d = 1'b1; end
            default: begin
              if (SELECT != OP_MUL && n_c == '0) begin
                result_d = DATA1;
                done_d   = 1'b1;
              end else begin
                load_c  = 1'b1;
                state_d = ITER;
              end
            end
          endcase
        end
      end
      ITER: begin
        if (last_c) begin
          result_d = iter_value_c;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == ITER);
    zero_d = (result_d == '0);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      RESULT  <= '0;
      ZERO    <= 1'b1;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state_q <= state_d;
      RESULT  <= result_d;
      ZERO    <= zero_d;
      BUSY    <= busy_d;
      DONE    <= done_d;
    end
  end

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk     (CLK),
    .reset   (RESET),
    .load    (load_c),
    .op      (SELECT),
    .a       (DATA1),
    .b       (DATA2),
    .n       (n_c),
    .last_c  (last_c),
    .value_c (iter_value_c)
  );

endmodule
